// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB PWM driver: colour codes, display modes
// and the colour-code to R/G/B pin mapping.
package rgb_pkg;

  localparam logic [2:0] CODE_RED     = 3'b000;
  localparam logic [2:0] CODE_YELLOW  = 3'b001;
  localparam logic [2:0] CODE_GREEN   = 3'b010;
  localparam logic [2:0] CODE_CYAN    = 3'b011;
  localparam logic [2:0] CODE_BLUE    = 3'b100;
  localparam logic [2:0] CODE_MAGENTA = 3'b101;
  localparam logic [2:0] CODE_OFF6    = 3'b110;
  localparam logic [2:0] CODE_OFF7    = 3'b111;

  // Mode 2'b11 is reserved and behaves as steady.
  typedef enum logic [1:0] {
    MODE_STEADY  = 2'b00,
    MODE_BLINK   = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  // Returns {R,G,B} enables for a colour code.
  function automatic logic [2:0] color_rgb(input logic [2:0] code);
    logic [2:0] rgb;
    case (code)
      CODE_RED:     rgb = 3'b100;
      CODE_YELLOW:  rgb = 3'b110;
      CODE_GREEN:   rgb = 3'b010;
      CODE_CYAN:    rgb = 3'b011;
      CODE_BLUE:    rgb = 3'b001;
      CODE_MAGENTA: rgb = 3'b101;
      default:      rgb = 3'b000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One RGB channel: double-buffered settings (shadow/active), effective duty
// selection for steady/blink/breathe, PWM compare and registered pin drive.
module rgb_pwm_channel
  import rgb_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic [2:0]          wr_code_i,
  input  logic [PWM_BITS-1:0] wr_duty_i,
  input  logic [1:0]          wr_mode_i,
  input  logic                commit_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                blink_phase_i,
  input  logic [PWM_BITS-1:0] breathe_lvl_i,
  output logic                red_o,
  output logic                green_o,
  output logic                blue_o
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  logic [2:0]            shadow_code_q, shadow_code_d;
  logic [PWM_BITS-1:0]   shadow_duty_q, shadow_duty_d;
  logic [1:0]            shadow_mode_q, shadow_mode_d;
  logic [2:0]            active_code_q, active_code_d;
  logic [PWM_BITS-1:0]   active_duty_q, active_duty_d;
  logic [1:0]            active_mode_q, active_mode_d;

  logic [2*PWM_BITS-1:0] breathe_prod;
  logic [PWM_BITS-1:0]   eff_duty;
  logic [2:0]            rgb;
  logic                  on;
  logic                  red_q, green_q, blue_q;
  logic                  red_d, green_d, blue_d;

  // Shadow takes host writes any time; active only changes at the period wrap.
  always_comb begin
    shadow_code_d = shadow_code_q;
    shadow_duty_d = shadow_duty_q;
    shadow_mode_d = shadow_mode_q;
    active_code_d = active_code_q;
    active_duty_d = active_duty_q;
    active_mode_d = active_mode_q;
    if (wr_en_i) begin
      shadow_code_d = wr_code_i;
      shadow_duty_d = wr_duty_i;
      shadow_mode_d = wr_mode_i;
    end
    // Commit copies the pre-write shadow, so a same-cycle write waits a period.
    if (commit_i) begin
      active_code_d = shadow_code_q;
      active_duty_d = shadow_duty_q;
      active_mode_d = shadow_mode_q;
    end
  end

  // Settings registers; reset to "off, duty 0, steady" and drop pending writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_code_q <= CODE_OFF6;
      shadow_duty_q <= '0;
      shadow_mode_q <= MODE_STEADY;
      active_code_q <= CODE_OFF6;
      active_duty_q <= '0;
      active_mode_q <= MODE_STEADY;
    end else begin
      shadow_code_q <= shadow_code_d;
      shadow_duty_q <= shadow_duty_d;
      shadow_mode_q <= shadow_mode_d;
      active_code_q <= active_code_d;
      active_duty_q <= active_duty_d;
      active_mode_q <= active_mode_d;
    end
  end

  // Effective duty: breathe scales duty by the shared level at full width.
  always_comb begin
    breathe_prod = {{PWM_BITS{1'b0}}, active_duty_q} * {{PWM_BITS{1'b0}}, breathe_lvl_i};
    eff_duty     = active_duty_q;
    case (mode_e'(active_mode_q))
      MODE_BLINK:   eff_duty = blink_phase_i ? active_duty_q : '0;
      // Full level passes duty through so breathe peaks at the set brightness.
      MODE_BREATHE: eff_duty = (breathe_lvl_i == DUTY_MAX) ? active_duty_q
                                                           : breathe_prod[2*PWM_BITS-1:PWM_BITS];
      default:      eff_duty = active_duty_q;
    endcase
  end

  // PWM compare gated by the colour map.
  always_comb begin
    rgb     = color_rgb(active_code_q);
    on      = (pwm_cnt_i < eff_duty);
    red_d   = on & rgb[2];
    green_d = on & rgb[1];
    blue_d  = on & rgb[0];
  end

  // Registered pins keep the outputs glitch-free.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      red_q   <= 1'b0;
      green_q <= 1'b0;
      blue_q  <= 1'b0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign red_o   = red_q;
  assign green_o = green_q;
  assign blue_o  = blue_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Multi-channel RGB PWM driver: shared PWM period counter, slow-tick
// prescaler, blink phase and breathe triangle, plus write decode to channels.
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int N_LEDS   = 2,
  parameter int PWM_BITS = 8,
  parameter int TICK_DIV = 1000000,
  localparam int CH_W    = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [2:0]          wr_code,
  input  logic [PWM_BITS-1:0] wr_duty,
  input  logic [1:0]          wr_mode,
  output logic [N_LEDS-1:0]   red,
  output logic [N_LEDS-1:0]   green,
  output logic [N_LEDS-1:0]   blue,
  output logic                period_start
);

  localparam int                  MAX_I    = (1 << PWM_BITS) - 1;
  localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(MAX_I - 1);
  localparam int                  PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PRE_W-1:0]    prescaler_q, prescaler_d;
  logic                blink_phase_q, blink_phase_d;
  logic [PWM_BITS-1:0] breathe_lvl_q, breathe_lvl_d;
  logic                breathe_up_q, breathe_up_d;
  logic                period_start_q, period_start_d;
  logic                commit;
  logic                tick;
  logic [N_LEDS-1:0]   wr_sel;

  assign commit = (pwm_cnt_q == CNT_LAST);
  assign tick   = (prescaler_q == PRE_LAST);

  // Period counter runs 0..MAX-1; the pulse marks the cycle pins show slot 0.
  always_comb begin
    pwm_cnt_d      = commit ? '0 : pwm_cnt_q + 1'b1;
    period_start_d = (pwm_cnt_q == '0);
  end

  // Slow tick drives the blink toggle and the breathe triangle 0..MAX..0.
  always_comb begin
    prescaler_d   = tick ? '0 : prescaler_q + 1'b1;
    blink_phase_d = blink_phase_q;
    breathe_lvl_d = breathe_lvl_q;
    breathe_up_d  = breathe_up_q;
    if (tick) begin
      blink_phase_d = ~blink_phase_q;
      if (breathe_up_q) begin
        breathe_lvl_d = breathe_lvl_q + 1'b1;
        if (breathe_lvl_q == LVL_MAX - 1'b1) breathe_up_d = 1'b0;
      end else begin
        breathe_lvl_d = breathe_lvl_q - 1'b1;
        if (breathe_lvl_q == PWM_BITS'(1)) breathe_up_d = 1'b1;
      end
    end
  end

  // Timing state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q      <= '0;
      prescaler_q    <= '0;
      blink_phase_q  <= 1'b1;
      breathe_lvl_q  <= '0;
      breathe_up_q   <= 1'b1;
      period_start_q <= 1'b0;
    end else begin
      pwm_cnt_q      <= pwm_cnt_d;
      prescaler_q    <= prescaler_d;
      blink_phase_q  <= blink_phase_d;
      breathe_lvl_q  <= breathe_lvl_d;
      breathe_up_q   <= breathe_up_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;

  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    // Out-of-range channel indices select nothing.
    assign wr_sel[i] = wr_en && (int'(wr_ch) == i);

    rgb_pwm_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk_i         (clk),
      .rst_i         (rst),
      .wr_en_i       (wr_sel[i]),
      .wr_code_i     (wr_code),
      .wr_duty_i     (wr_duty),
      .wr_mode_i     (wr_mode),
      .commit_i      (commit),
      .pwm_cnt_i     (pwm_cnt_q),
      .blink_phase_i (blink_phase_q),
      .breathe_lvl_i (breathe_lvl_q),
      .red_o         (red[i]),
      .green_o       (green[i]),
      .blue_o        (blue[i])
    );
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Scoreboard bench for rgb_pwm_driver. The driver computes each cycle's
// expected pins from a time-based reference model and queues them; a monitor
// pops and compares on the falling edge.
module tb_rgb_pwm_driver;

  localparam int N_LEDS   = 2;
  localparam int PWM_BITS = 4;
  localparam int TICK_DIV = 4;
  localparam int MAXV     = 15;
  localparam int CH_W     = 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                wr_en;
  logic [CH_W-1:0]     wr_ch;
  logic [2:0]          wr_code;
  logic [PWM_BITS-1:0] wr_duty;
  logic [1:0]          wr_mode;
  logic [N_LEDS-1:0]   red, green, blue;
  logic                period_start;

  always #5 clk = ~clk;

  rgb_pwm_driver #(
    .N_LEDS   (N_LEDS),
    .PWM_BITS (PWM_BITS),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_code      (wr_code),
    .wr_duty      (wr_duty),
    .wr_mode      (wr_mode),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .period_start (period_start)
  );

  typedef struct packed {
    int                tag;
    logic [N_LEDS-1:0] r;
    logic [N_LEDS-1:0] g;
    logic [N_LEDS-1:0] b;
    logic              ps;
  } exp_t;

  exp_t  expq[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;
  string scen = "init";

  // Colour table {R,G,B} indexed by code.
  logic [2:0] cmap [8] = '{3'b100, 3'b110, 3'b010, 3'b011,
                           3'b001, 3'b101, 3'b000, 3'b000};

  // Reference model: t = cycles since reset release; everything else derives from it.
  int t = 0;
  int sh_code [N_LEDS];
  int sh_duty [N_LEDS];
  int sh_mode [N_LEDS];
  int ac_code [N_LEDS];
  int ac_duty [N_LEDS];
  int ac_mode [N_LEDS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < N_LEDS; i++) begin
      sh_code[i] = 6; sh_duty[i] = 0; sh_mode[i] = 0;
      ac_code[i] = 6; ac_duty[i] = 0; ac_mode[i] = 0;
    end
  endtask

  // Drive one cycle of inputs, queue the pins expected after the next edge.
  task automatic step(input bit r, input bit we, input int ch, input int code,
                      input int duty, input int mode);
    exp_t e;
    int   cnt, k, lvl, eff, wch;
    bit   ph, on;
    logic [2:0] rgb;
    rst     = r;
    wr_en   = we;
    wr_ch   = CH_W'(ch);
    wr_code = 3'(code);
    wr_duty = PWM_BITS'(duty);
    wr_mode = 2'(mode);
    e = '0;
    e.tag = cyc + 1;
    if (r) begin
      model_reset();
    end else begin
      cnt = t % MAXV;
      k   = (t / TICK_DIV) % (2 * MAXV);
      lvl = (k <= MAXV) ? k : 2 * MAXV - k;
      ph  = ((t / TICK_DIV) % 2) == 0;
      for (int i = 0; i < N_LEDS; i++) begin
        if (ac_mode[i] == 1)      eff = ph ? ac_duty[i] : 0;
        else if (ac_mode[i] == 2) eff = (lvl == MAXV) ? ac_duty[i] : (ac_duty[i] * lvl) / 16;
        else                      eff = ac_duty[i];
        on  = cnt < eff;
        rgb = cmap[ac_code[i]];
        e.r[i] = on & rgb[2];
        e.g[i] = on & rgb[1];
        e.b[i] = on & rgb[0];
      end
      e.ps = (cnt == 0);
      if (cnt == MAXV - 1) begin
        for (int i = 0; i < N_LEDS; i++) begin
          ac_code[i] = sh_code[i]; ac_duty[i] = sh_duty[i]; ac_mode[i] = sh_mode[i];
        end
      end
      wch = int'(wr_ch);
      if (we && wch < N_LEDS) begin
        sh_code[wch] = code; sh_duty[wch] = duty; sh_mode[wch] = mode;
      end
      t++;
    end
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int ch, input int code, input int duty, input int mode);
    step(0, 1, ch, code, duty, mode);
  endtask

  // Idle until the next driven cycle is the given period slot.
  task automatic idle_until(input int slot);
    for (int i = 0; i < 2 * MAXV && (t % MAXV) != slot; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare the DUT pins against the queued expectation for this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0 && expq[0].tag == cyc) begin
      e = expq.pop_front();
      n_checks++;
      if ({red, green, blue, period_start} === {e.r, e.g, e.b, e.ps}) begin
        n_pass++;
      end else begin
        $display("FAIL %s cyc=%0d: actual r=%b g=%b b=%b ps=%b, required r=%b g=%b b=%b ps=%b",
                 scen, cyc, red, green, blue, period_start, e.r, e.g, e.b, e.ps);
      end
    end
  end

  initial begin
    model_reset();
    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_code = '0; wr_duty = '0; wr_mode = '0;
    @(posedge clk);
    #1;

    scen = "reset";
    step(1, 1, 0, 1, 5, 0);
    step(1, 1, 1, 4, 15, 0);
    step(1, 1, 0, 2, 9, 1);
    scen = "after_reset";
    idle(20);

    scen = "steady";
    idle_until(3);
    wr(0, 1, 5, 0);
    idle(40);
    wr(1, 4, 15, 0);
    idle(35);

    scen = "commit_edge";
    idle_until(14);
    wr(0, 0, 8, 0);
    idle(35);
    scen = "last_write_wins";
    idle_until(2);
    wr(0, 0, 3, 0);
    idle(3);
    wr(0, 0, 9, 0);
    idle(35);

    scen = "blink";
    wr(0, 2, 15, 1);
    idle(60);
    scen = "off_codes";
    wr(0, 6, 15, 0);
    wr(1, 7, 15, 2);
    idle(35);

    scen = "breathe";
    wr(1, 5, 15, 2);
    idle(150);
    wr(0, 3, 11, 2);
    idle(130);

    scen = "random";
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0)
        step(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 15), $urandom_range(0, 3));
      else if ($urandom_range(0, 3) == 0)
        wr($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 15),
           $urandom_range(0, 3));
      else
        idle(1);
    end

    scen = "mid_reset";
    wr(0, 1, 15, 0);
    wr(1, 3, 15, 0);
    idle(20);
    idle_until(7);
    step(1, 0, 0, 0, 0, 0);
    idle(20);

    scen = "drain";
    @(negedge clk);
    #1;
    n_checks++;
    if (expq.size() == 0) n_pass++;
    else $display("FAIL drain: actual %0d expectations left, required 0", expq.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
